// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, parity constants and divider limit.
//   uart_rx_state_e : receiver FSM states
//   PARITY_ODD/EVEN : encoding of the parity mode input
//   BAUD_DIV_MIN    : smallest usable baud divider
//   parity_bit()    : expected parity bit from the XOR of the data bits
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} uart_rx_state_e;
   localparam logic PARITY_ODD = 1'b0;
   localparam logic PARITY_EVEN = 1'b1;
   localparam int unsigned BAUD_DIV_MIN = 4;
   function automatic logic parity_bit(input logic mode, input logic data_xor);
      return (mode == PARITY_EVEN) ? data_xor : ~data_xor;
   endfunction
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for asynchronous inputs.
//   clk, rst : clock, asynchronous active-high reset (flops take RST_VAL)
//   d_i      : asynchronous input
//   q_o      : synchronized output
module uart_sync2 #(
   parameter int W = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] s1_q, s2_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= RST_VAL;
         s2_q <= RST_VAL;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end
   assign q_o = s2_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, serial line to parallel words with valid/ready.
//   clk, rst            : clock, asynchronous active-high reset
//   en_i                : receiver enable; low aborts a frame in progress
//   stop_bits_i         : 0 = one stop bit, 1 = two
//   parity_bit_i        : a parity bit follows the data
//   parity_bit_mode_i   : 0 = odd, 1 = even parity
//   baud_div_i          : bit period in clk cycles
//   rx_i                : asynchronous serial input, idles high
//   rx_data_o/rx_valid_o/rx_ready_i : received word handshake
//   parity_err_o, frame_err_o       : error flags qualified by rx_valid_o
//   overrun_o           : one-cycle pulse when a completed frame is dropped
//   busy_o              : a frame is in progress
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int BAUD_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_i,
   input  logic              stop_bits_i,
   input  logic              parity_bit_i,
   input  logic              parity_bit_mode_i,
   input  logic [BAUD_W-1:0] baud_div_i,
   input  logic              rx_i,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              rx_valid_o,
   input  logic              rx_ready_i,
   output logic              parity_err_o,
   output logic              frame_err_o,
   output logic              overrun_o,
   output logic              busy_o
);
   localparam int CNT_W = $clog2(DATA_W);
   uart_rx_state_e state_q, state_d;
   logic [BAUD_W-1:0] cnt_q, cnt_d, div_q, div_d, div_sel;
   logic [CNT_W-1:0] bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d, data_q, data_d;
   logic two_stop_q, two_stop_d, par_en_q, par_en_d, par_mode_q, par_mode_d;
   logic perr_q, perr_d, ferr_q, ferr_d, done_q, done_d;
   logic valid_q, valid_d, perr_o_q, perr_o_d, ferr_o_q, ferr_o_d, ovr_q, ovr_d;
   logic rx_s, edge_q, tick, fall, load;

   uart_sync2 #(.W(1), .RST_VAL(1'b1)) u_sync (
      .clk(clk),
      .rst(rst),
      .d_i(rx_i),
      .q_o(rx_s)
   );

   assign div_sel = (baud_div_i < BAUD_W'(BAUD_DIV_MIN)) ? BAUD_W'(BAUD_DIV_MIN) : baud_div_i;
   // counter holds the cycles left before the next sample edge
   assign tick = cnt_q == '0;
   assign fall = en_i && edge_q && !rx_s;

   always_comb begin
      state_d = state_q;
      cnt_d = tick ? cnt_q : cnt_q - 1'b1;
      div_d = div_q;
      bit_d = bit_q;
      shift_d = shift_q;
      two_stop_d = two_stop_q;
      par_en_d = par_en_q;
      par_mode_d = par_mode_q;
      perr_d = perr_q;
      ferr_d = ferr_q;
      done_d = 1'b0;
      case (state_q)
         IDLE: if (fall) begin
            state_d = START;
            cnt_d = (div_sel >> 1) - 1'b1;
            div_d = div_sel;
            two_stop_d = stop_bits_i;
            par_en_d = parity_bit_i;
            par_mode_d = parity_bit_mode_i;
            bit_d = '0;
            perr_d = 1'b0;
            ferr_d = 1'b0;
         end
         START: if (tick) begin
            state_d = rx_s ? IDLE : DATA;
            cnt_d = div_q - 1'b1;
         end
         DATA: if (tick) begin
            shift_d = {rx_s, shift_q[DATA_W-1:1]};
            cnt_d = div_q - 1'b1;
            bit_d = bit_q + 1'b1;
            if (bit_q == CNT_W'(DATA_W - 1)) state_d = par_en_q ? PARITY : STOP1;
         end
         PARITY: if (tick) begin
            perr_d = rx_s != parity_bit(par_mode_q, ^shift_q);
            cnt_d = div_q - 1'b1;
            state_d = STOP1;
         end
         STOP1: if (tick) begin
            ferr_d = !rx_s;
            cnt_d = div_q - 1'b1;
            state_d = two_stop_q ? STOP2 : IDLE;
            done_d = !two_stop_q;
         end
         STOP2: if (tick) begin
            ferr_d = ferr_q || !rx_s;
            state_d = IDLE;
            done_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (!en_i) begin
         state_d = IDLE;
         done_d = 1'b0;
      end
   end

   // completed frame is presented one cycle after the last stop sample
   always_comb begin
      load = done_q && (!valid_q || rx_ready_i);
      data_d = load ? shift_q : data_q;
      perr_o_d = load ? perr_q : perr_o_q;
      ferr_o_d = load ? ferr_q : ferr_o_q;
      valid_d = load || (valid_q && !rx_ready_i);
      ovr_d = done_q && !load;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         edge_q <= 1'b1;
         cnt_q <= '0;
         div_q <= '0;
         bit_q <= '0;
         shift_q <= '0;
         two_stop_q <= 1'b0;
         par_en_q <= 1'b0;
         par_mode_q <= 1'b0;
         perr_q <= 1'b0;
         ferr_q <= 1'b0;
         done_q <= 1'b0;
         data_q <= '0;
         valid_q <= 1'b0;
         perr_o_q <= 1'b0;
         ferr_o_q <= 1'b0;
         ovr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         edge_q <= rx_s;
         cnt_q <= cnt_d;
         div_q <= div_d;
         bit_q <= bit_d;
         shift_q <= shift_d;
         two_stop_q <= two_stop_d;
         par_en_q <= par_en_d;
         par_mode_q <= par_mode_d;
         perr_q <= perr_d;
         ferr_q <= ferr_d;
         done_q <= done_d;
         data_q <= data_d;
         valid_q <= valid_d;
         perr_o_q <= perr_o_d;
         ferr_o_q <= ferr_o_d;
         ovr_q <= ovr_d;
      end
   end

   assign rx_data_o = data_q;
   assign rx_valid_o = valid_q;
   assign parity_err_o = perr_o_q;
   assign frame_err_o = ferr_o_q;
   assign overrun_o = ovr_q;
   assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed vector bench for uart_rx.
module tb_uart_rx;
   logic clk = 1'b0;
   logic rst, en, sb, pb, pm, rx, ready;
   logic [15:0] div;
   logic [7:0] data;
   logic valid, pe, fe, ovr, busy;
   int checks = 0, failures = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   uart_rx dut (
      .clk(clk),
      .rst(rst),
      .en_i(en),
      .stop_bits_i(sb),
      .parity_bit_i(pb),
      .parity_bit_mode_i(pm),
      .baud_div_i(div),
      .rx_i(rx),
      .rx_data_o(data),
      .rx_valid_o(valid),
      .rx_ready_i(ready),
      .parity_err_o(pe),
      .frame_err_o(fe),
      .overrun_o(ovr),
      .busy_o(busy)
   );

   always @(posedge clk) cyc <= cyc + 1;

   logic vprev = 1'b0, bprev = 1'b0;
   int rise_cyc = 0, rises = 0, ovr_cnt = 0, busy_rise = 0, busy_fall = 0;
   logic [7:0] cap_data = '0;
   logic cap_pe = 1'b0, cap_fe = 1'b0;
   always @(negedge clk) begin
      if (valid && !vprev) begin
         rise_cyc <= cyc;
         cap_data <= data;
         cap_pe <= pe;
         cap_fe <= fe;
         rises <= rises + 1;
      end
      if (busy && !bprev) busy_rise <= cyc;
      if (!busy && bprev) busy_fall <= cyc;
      if (ovr) ovr_cnt <= ovr_cnt + 1;
      vprev <= valid;
      bprev <= busy;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // drives one frame; config inputs are scrambled after the start bit
   task automatic send(input logic [7:0] d, input logic pen, pmode, pv, two, s1v, s2v,
                       input int baud, gap, output int t0);
      logic [11:0] b;
      int n;
      div = 16'(baud);
      pb = pen;
      pm = pmode;
      sb = two;
      b = '1;
      b[0] = 1'b0;
      b[8:1] = d;
      n = 9;
      if (pen) begin
         b[n] = pv;
         n++;
      end
      b[n] = s1v;
      n++;
      if (two) begin
         b[n] = s2v;
         n++;
      end
      @(posedge clk);
      #1;
      t0 = cyc + 1;
      for (int i = 0; i < n; i++) begin
         rx = b[i];
         if (i == 1) begin
            div = 16'd7;
            pb = ~pen;
            pm = ~pmode;
            sb = ~two;
         end
         repeat (baud) @(posedge clk);
         #1;
      end
      rx = 1'b1;
      repeat (gap) @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [7:0] d;
      logic pen, pm, pv, two, s1, s2;
      int baud;
      logic [7:0] ed;
      logic epe, efe;
      int lat;
   } vec_t;
   vec_t v[8];

   initial begin
      int t0, r0, o0;
      v[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 8'hA5, 1'b0, 1'b0, 155};
      v[1] = '{8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16, 8'h03, 1'b0, 1'b0, 171};
      v[2] = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16, 8'h03, 1'b1, 1'b0, 171};
      v[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16, 8'h5A, 1'b0, 1'b1, 171};
      v[4] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 8'h01, 1'b0, 1'b0, 171};
      v[5] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16, 8'hFF, 1'b0, 1'b0, 187};
      v[6] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16, 8'h00, 1'b0, 1'b1, 155};
      v[7] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 8'h3C, 1'b0, 1'b0, 41};
      rst = 1'b1;
      en = 1'b1;
      sb = 1'b0;
      pb = 1'b0;
      pm = 1'b0;
      rx = 1'b1;
      ready = 1'b1;
      div = 16'd16;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_data", data, 0);
      chk("reset_valid", valid, 0);
      chk("reset_perr", pe, 0);
      chk("reset_ferr", fe, 0);
      chk("reset_ovr", ovr, 0);
      chk("reset_busy", busy, 0);

      for (int i = 0; i < 8; i++) begin
         r0 = rises;
         send(v[i].d, v[i].pen, v[i].pm, v[i].pv, v[i].two, v[i].s1, v[i].s2, v[i].baud, 4, t0);
         @(negedge clk);
         chk($sformatf("vec%0d_count", i), rises - r0, 1);
         chk($sformatf("vec%0d_latency", i), rise_cyc - t0, v[i].lat);
         chk($sformatf("vec%0d_data", i), cap_data, v[i].ed);
         chk($sformatf("vec%0d_perr", i), cap_pe, v[i].epe);
         chk($sformatf("vec%0d_ferr", i), cap_fe, v[i].efe);
      end

      // false start: line low for three cycles only
      r0 = rises;
      div = 16'd16;
      @(posedge clk);
      #1 rx = 1'b0;
      t0 = cyc + 1;
      repeat (3) @(posedge clk);
      #1 rx = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("false_busy_rise", busy_rise - t0, 2);
      chk("false_busy_fall", busy_fall - t0, 10);
      chk("false_no_valid", rises - r0, 0);

      // back-to-back frames with the consumer stalled
      ready = 1'b0;
      r0 = rises;
      o0 = ovr_cnt;
      send(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 0, t0);
      send(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 6, t0);
      @(negedge clk);
      chk("ovr_data_kept", data, 8'h11);
      chk("ovr_valid_held", valid, 1);
      chk("ovr_pulses", ovr_cnt - o0, 1);
      chk("ovr_single_rise", rises - r0, 1);
      @(posedge clk);
      #1 ready = 1'b1;
      @(posedge clk);
      #1 ready = 1'b0;
      @(negedge clk);
      chk("xfer_valid_fall", valid, 0);

      // disable mid-frame aborts it
      ready = 1'b1;
      r0 = rises;
      @(posedge clk);
      #1 rx = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      chk("en_busy_before", busy, 1);
      en = 1'b0;
      @(posedge clk);
      #1;
      chk("en_busy_after", busy, 0);
      rx = 1'b1;
      en = 1'b1;
      repeat (200) @(posedge clk);
      @(negedge clk);
      chk("en_no_valid", rises - r0, 0);

      // reset during DATA with a pending word
      ready = 1'b0;
      send(8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 4, t0);
      @(negedge clk);
      chk("rst_pending_valid", valid, 1);
      div = 16'd16;
      @(posedge clk);
      #1 rx = 1'b0;
      repeat (40) @(posedge clk);
      #3;
      chk("rst_busy_before", busy, 1);
      rst = 1'b1;
      rx = 1'b1;
      #1;
      chk("rst_data", data, 0);
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_flags", {pe, fe, ovr}, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      r0 = rises;
      send(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 4, t0);
      @(negedge clk);
      chk("post_rst_count", rises - r0, 1);
      chk("post_rst_latency", rise_cyc - t0, 155);
      chk("post_rst_data", cap_data, 8'hC3);
      chk("post_rst_flags", {cap_pe, cap_fe}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART peripheral, the counterpart to the transmitter on the same link. Converts the serial line `rx_i` into 8-bit parallel words and presents them to the controller through a valid/ready handshake. It uses the same per-frame configuration as the transmitter (enable, stop bits, parity, baud divider) and flags parity, framing and overrun errors. It sits between the pad/loopback and the AXI-Lite register bridge.

## Interface
Parameters:
- `DATA_W`, 8: data bits per frame; bits are sent LSB first.
- `BAUD_W`, 16: width of the baud divider.

Ports:
- `clk`  in  1  system clock; the block uses one clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `en_i`  in  1  receiver enable.
- `stop_bits_i`  in  1  0 = one stop bit, 1 = two stop bits.
- `parity_bit_i`  in  1  1 = a parity bit follows the data bits.
- `parity_bit_mode_i`  in  1  0 = odd parity, 1 = even parity.
- `baud_div_i`  in  `BAUD_W`  bit period in `clk` cycles; minimum legal value is 4.
- `rx_i`  in  1  serial input; asynchronous to `clk`; idles high.
- `rx_data_o`  out  `DATA_W`  received word.
- `rx_valid_o`  out  1  `rx_data_o` and the error flags are valid.
- `rx_ready_i`  in  1  controller accepts the word.
- `parity_err_o`  out  1  parity mismatch; qualified by `rx_valid_o`.
- `frame_err_o`  out  1  a stop bit was sampled low; qualified by `rx_valid_o`.
- `overrun_o`  out  1  one-cycle pulse: a completed frame was dropped.
- `busy_o`  out  1  a frame is in progress (state is not IDLE).

## Operation
- `rx_i` passes through a 2-flop synchronizer (flops reset to 1), then a 1-flop edge register.
- Start detection: in IDLE with `en_i`=1, a high-to-low transition of the synchronized line.
  - Detection is edge-based, so a held-low line (break) does not retrigger.
- At start detection, the block latches `baud_div_i`, `stop_bits_i`, `parity_bit_i` and `parity_bit_mode_i`.
  - Changes to these inputs during a frame are ignored.
- A down-counter is loaded with `baud_div>>1`, so sampling lands at mid-bit. After that it reloads `baud_div-1` for each subsequent bit.
- States:
  - IDLE → START on start detection.
  - START: sample at mid-bit. Line high = false start → IDLE. Line low → DATA.
  - DATA: shift `DATA_W` samples LSB first. Then → PARITY if parity is enabled, else → STOP1.
  - PARITY: compare the sample with the expected parity bit. Even mode: bit = XOR of data. Odd mode: bit = NOT XOR of data.
  - STOP1: sample the stop bit. → STOP2 if two stop bits are configured, else complete the frame.
  - STOP2: sample the second stop bit, then complete the frame.
- Frame complete: return to IDLE in the same cycle as the last stop sample, at mid-stop-bit, so back-to-back frames are caught.
- Output register behaviour at frame complete:
  - If `rx_valid_o`=0 or `rx_ready_i`=1 that cycle: load data and flags, set `rx_valid_o`.
  - Otherwise keep the old word and pulse `overrun_o`.
- Framing errors do not suppress delivery. The word is delivered with `frame_err_o`=1.
- `en_i` low: state → IDLE next cycle and any frame in progress is aborted. A pending output word is kept.

## Timing
- Reset values: `rx_data_o`=0, `rx_valid_o`=0, all error flags 0, `busy_o`=0, state IDLE, synchronizer flops 1.
- Let t0 be the cycle in which `rx_i` falls. Start is detected at t0+2, where `busy_o` goes high.
  - Start sample: t0+2+`baud_div>>1`.
  - Each later bit is sampled `baud_div` cycles after the previous one.
- `rx_valid_o` rises 1 cycle after the last stop sample.
  - 8N1 with `baud_div`=16: t0+155.
  - 8E2: t0+187.
- Handshake: the word transfers on a cycle where `rx_valid_o`=1 and `rx_ready_i`=1. `rx_valid_o` falls the next cycle unless a new frame completes in that same cycle.
  - If a frame completes in a transfer cycle, `rx_valid_o` stays 1 and the new word is loaded. This is not an overrun.
- `rx_data_o` and the error flags stay stable while `rx_valid_o`=1 and `rx_ready_i`=0.

## Structure
- Shared package `uart_pkg`:
  - `uart_rx_state_e` enum (IDLE, START, DATA, PARITY, STOP1, STOP2).
  - `PARITY_ODD`=0 and `PARITY_EVEN`=1 constants, also used by the transmitter.
  - The minimum divider constant, 4.
- Sub-module `uart_sync2`: a parameterized 2-flop synchronizer with a reset value parameter. It is reusable for other async inputs.

## Test plan
- 8N1, `baud_div`=16, send 0xA5 → `rx_data_o`=0xA5 and `rx_valid_o` at t0+155, with no errors.
- 8E1, send 0x03 with parity bit 0 → no error. Repeat with parity bit 1 → `parity_err_o`=1 and data 0x03.
- 8N2, second stop bit driven 0, data 0x5A → `rx_valid_o`=1, `frame_err_o`=1, data 0x5A.
- `rx_i` low for 3 cycles, `baud_div`=16 → `busy_o` pulses and drops at the start sample, and `rx_valid_o` stays 0.
- Two back-to-back 8N1 frames 0x11 and 0x22 with `rx_ready_i`=0 → `rx_data_o` stays 0x11 and `overrun_o` pulses once. Raise `rx_ready_i` → word transfers and `rx_valid_o` falls.
- `rst` asserted mid-DATA, then a fresh frame 0xC3 → all outputs 0 immediately, then 0xC3 is received correctly.
